// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a synchronous memory with a
// one-cycle registered read. Issues sequential read addresses, absorbs the
// read latency and hands words to decode over a valid/ready handshake, with a
// 2-entry skid buffer and branch/jump redirect that flushes stale words.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mem_re/mem_raddr  memory read request (combinational)
//   mem_rdata         memory read data, valid the cycle after mem_re=1
//   insn_valid/insn_data/insn_pc/insn_ready  handshake towards decode
//   redirect/redirect_pc                     restart fetch at a new address
module fetch_unit #(
  parameter int                AWIDTH   = 16,
  parameter int                DWIDTH   = 16,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              insn_valid,
  output logic [DWIDTH-1:0] insn_data,
  output logic [AWIDTH-1:0] insn_pc,
  input  logic              insn_ready,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc
);

  logic [AWIDTH-1:0] pc_reg;
  logic              inflight_reg;
  logic [AWIDTH-1:0] inflight_pc_reg;
  logic [1:0]        count_reg;
  logic              head_reg;
  logic              tail_reg;

  logic [DWIDTH-1:0] buf_data [2];
  logic [AWIDTH-1:0] buf_pc   [2];

  logic       transfer;
  logic       bypass;
  logic       push;
  logic       pop;
  logic [1:0] occupancy;
  logic       issue;

  // Output selection: buffer head first, otherwise the word returning from
  // memory this cycle is passed straight through.
  always_comb begin
    insn_valid = 1'b0;
    insn_data  = '0;
    insn_pc    = '0;
    if (!rst && !redirect) begin
      if (count_reg != 2'd0) begin
        insn_valid = 1'b1;
        insn_data  = buf_data[head_reg];
        insn_pc    = buf_pc[head_reg];
      end else if (inflight_reg) begin
        insn_valid = 1'b1;
        insn_data  = mem_rdata;
        insn_pc    = inflight_pc_reg;
      end
    end
  end

  assign transfer = insn_valid && insn_ready;
  assign bypass   = transfer && (count_reg == 2'd0);
  assign pop      = transfer && (count_reg != 2'd0);
  // A returning word not consumed directly must be captured now: memory data
  // is only guaranteed for this one cycle. On redirect it is stale and dropped.
  assign push     = inflight_reg && !bypass && !redirect;

  // Words that will be held next cycle if nothing new is issued. Keeping this
  // below 2 before issuing guarantees the buffer can never overflow.
  assign occupancy = count_reg + {1'b0, inflight_reg} - {1'b0, transfer};
  assign issue     = (occupancy < 2'd2);

  assign mem_re    = !rst && (redirect || issue);
  assign mem_raddr = rst ? RESET_PC : (redirect ? redirect_pc : pc_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= 2'd0;
      head_reg        <= 1'b0;
      tail_reg        <= 1'b0;
    end else if (redirect) begin
      pc_reg          <= redirect_pc + AWIDTH'(1);
      inflight_reg    <= 1'b1;
      inflight_pc_reg <= redirect_pc;
      count_reg       <= 2'd0;
      head_reg        <= 1'b0;
      tail_reg        <= 1'b0;
    end else begin
      assert (!(push && !pop && count_reg == 2'd2))
        else $error("fetch_unit: skid buffer overflow");
      if (push) tail_reg <= ~tail_reg;
      if (pop)  head_reg <= ~head_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        pc_reg          <= pc_reg + AWIDTH'(1);
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= pc_reg;
      end else begin
        inflight_reg <= 1'b0;
      end
    end
  end

  // Skid buffer storage: plain data registers, no reset needed since count
  // gates every read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (tail_reg == 1'(gi))) begin
        buf_data[gi] <= mem_rdata;
        buf_pc[gi]   <= inflight_pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        insn_ready;

  logic        mem_re,     w_mem_re;
  logic [15:0] mem_raddr,  w_mem_raddr;
  logic [15:0] mem_rdata,  w_mem_rdata;
  logic        insn_valid, w_insn_valid;
  logic [15:0] insn_data,  w_insn_data;
  logic [15:0] insn_pc,    w_insn_pc;

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  fetch_unit #(.AWIDTH(16), .DWIDTH(16), .RESET_PC(16'h0010)) dut (
    .clk(clk), .rst(rst),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .insn_valid(insn_valid), .insn_data(insn_data), .insn_pc(insn_pc),
    .insn_ready(insn_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // Second instance starting near the top of the address space.
  fetch_unit #(.AWIDTH(16), .DWIDTH(16), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst),
    .mem_re(w_mem_re), .mem_raddr(w_mem_raddr), .mem_rdata(w_mem_rdata),
    .insn_valid(w_insn_valid), .insn_data(w_insn_data), .insn_pc(w_insn_pc),
    .insn_ready(1'b1), .redirect(1'b0), .redirect_pc(16'h0000)
  );

  function automatic logic [15:0] memv(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Memory models: mem[i] = i ^ 0xA5A5, garbage when not read.
  always @(posedge clk) begin
    mem_rdata   <= mem_re   ? memv(mem_raddr)   : 16'hDEAD;
    w_mem_rdata <= w_mem_re ? memv(w_mem_raddr) : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic expect_word(input string tag, input logic [15:0] pc);
    check({tag, " valid"}, {31'd0, insn_valid}, 32'd1);
    check({tag, " pc"},    {16'd0, insn_pc},    {16'd0, pc});
    check({tag, " data"},  {16'd0, insn_data},  {16'd0, memv(pc)});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] wpc;
    int          xfers;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; insn_ready = 1'b0;

    // Reset state
    repeat (3) step();
    #1;
    check("rst valid", {31'd0, insn_valid}, 32'd0);
    check("rst mem_re", {31'd0, mem_re}, 32'd0);
    check("rst raddr", {16'd0, mem_raddr}, 32'h0010);
    check("rst data", {16'd0, insn_data}, 32'd0);
    check("rst pc", {16'd0, insn_pc}, 32'd0);
    check("rst wrap raddr", {16'd0, w_mem_raddr}, 32'hFFFE);
    $display("reset state checked");

    // Reset release: first issue on the first cycle with rst=0
    step(); rst = 1'b0; insn_ready = 1'b1; #1;
    check("rel1 valid", {31'd0, insn_valid}, 32'd0);
    check("rel1 mem_re", {31'd0, mem_re}, 32'd1);
    check("rel1 raddr", {16'd0, mem_raddr}, 32'h0010);
    check("rel1 wrap raddr", {16'd0, w_mem_raddr}, 32'hFFFE);
    wpc = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      expect_word("stream", 16'h0010 + 16'(i));
      check("stream mem_re", {31'd0, mem_re}, 32'd1);
      check("stream raddr", {16'd0, mem_raddr}, 32'h0011 + 32'(i));
      check("wrap valid", {31'd0, w_insn_valid}, 32'd1);
      check("wrap pc", {16'd0, w_insn_pc}, {16'd0, wpc});
      check("wrap data", {16'd0, w_insn_data}, {16'd0, memv(wpc)});
      $display("stream pc=%h data=%h | wrap pc=%h data=%h", insn_pc, insn_data, w_insn_pc, w_insn_data);
      wpc = wpc + 16'd1;
    end

    // Stall for 5 cycles: bypass word captured, then buffer fills, mem_re drops
    step(); insn_ready = 1'b0; #1;
    expect_word("stall0", 16'h0014);
    check("stall0 mem_re", {31'd0, mem_re}, 32'd1);
    check("stall0 raddr", {16'd0, mem_raddr}, 32'h0015);
    for (int i = 1; i < 5; i++) begin
      step(); #1;
      expect_word("stall hold", 16'h0014);
      check("stall mem_re", {31'd0, mem_re}, 32'd0);
    end
    $display("stall held pc=%h data=%h", insn_pc, insn_data);
    exp_pc = 16'h0014;
    for (int i = 0; i < 6; i++) begin
      step(); insn_ready = 1'b1; #1;
      expect_word("drain", exp_pc);
      $display("drain pc=%h data=%h", insn_pc, insn_data);
      exp_pc = exp_pc + 16'd1;
    end

    // Fill the buffer with 2 words, then redirect
    step(); insn_ready = 1'b0; #1;
    expect_word("fill a", exp_pc);
    check("fill a mem_re", {31'd0, mem_re}, 32'd0);
    step(); #1;
    expect_word("fill b", exp_pc);
    check("fill b mem_re", {31'd0, mem_re}, 32'd0);
    step(); redirect = 1'b1; redirect_pc = 16'h0200; insn_ready = 1'b1; #1;
    check("redir valid", {31'd0, insn_valid}, 32'd0);
    check("redir mem_re", {31'd0, mem_re}, 32'd1);
    check("redir raddr", {16'd0, mem_raddr}, 32'h0200);
    $display("redirect to 0200");
    exp_pc = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      step(); redirect = 1'b0; #1;
      expect_word("after redir", exp_pc);
      $display("after redirect pc=%h data=%h", insn_pc, insn_data);
      exp_pc = exp_pc + 16'd1;
    end

    // Back-to-back redirects: only the last one produces output
    step(); redirect = 1'b1; redirect_pc = 16'h0300; #1;
    check("b2b1 raddr", {16'd0, mem_raddr}, 32'h0300);
    step(); redirect_pc = 16'h0400; #1;
    check("b2b2 valid", {31'd0, insn_valid}, 32'd0);
    check("b2b2 raddr", {16'd0, mem_raddr}, 32'h0400);
    step(); redirect = 1'b0; #1;
    expect_word("b2b out0", 16'h0400);
    step(); #1;
    expect_word("b2b out1", 16'h0401);
    $display("back-to-back redirect pc=%h", insn_pc);

    // Redirect during stall, then random ready for 200 cycles
    step(); redirect = 1'b1; redirect_pc = 16'h0500; insn_ready = 1'b0; #1;
    check("rs valid", {31'd0, insn_valid}, 32'd0);
    check("rs raddr", {16'd0, mem_raddr}, 32'h0500);
    step(); redirect = 1'b0;
    exp_pc = 16'h0500;
    xfers = 0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) step();
      insn_ready = 1'($urandom_range(0, 1));
      #1;
      expect_word("rand", exp_pc);
      if (insn_ready) begin
        exp_pc = exp_pc + 16'd1;
        xfers++;
      end
    end
    check("rand progress", {31'd0, xfers > 40}, 32'd1);
    $display("random ready: %0d transfers, last pc=%h", xfers, exp_pc - 16'd1);

    // Reset during a full-buffer stall
    step(); insn_ready = 1'b0;
    step(); step(); step();
    step(); rst = 1'b1; #1;
    check("mrst valid", {31'd0, insn_valid}, 32'd0);
    check("mrst mem_re", {31'd0, mem_re}, 32'd0);
    check("mrst raddr", {16'd0, mem_raddr}, 32'h0010);
    step(); rst = 1'b0; insn_ready = 1'b1; #1;
    check("mrst rel valid", {31'd0, insn_valid}, 32'd0);
    check("mrst rel mem_re", {31'd0, mem_re}, 32'd1);
    check("mrst rel raddr", {16'd0, mem_raddr}, 32'h0010);
    step(); #1;
    expect_word("mrst out0", 16'h0010);
    step(); #1;
    expect_word("mrst out1", 16'h0011);
    $display("restart after reset pc=%h data=%h", insn_pc, insn_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
